mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory of the multicycle MIPS between two requesters:
//  the CPU (datapath IorD/MemRead/MemWrite path, sequenced by the controller) and a DMA/loader port.
//  Sits between the requesters and the memory.
//  Serialises accesses, holds each access stable for a fixed memory latency, and returns data plus a one-cycle ack.
//  Fair 2-way round-robin arbitration.
// PARAMETERS
//  ADDR_W   32  byte-address width
//  DATA_W   32  word width (memory is big-endian, byte-addressed)
//  MEM_LAT  2   cycles each access is driven to memory; legal range >= 1
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  cpu_req    in   1       CPU access request; held until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   ADDR_W  CPU byte address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_rdata  out  DATA_W  CPU read data, registered
//  cpu_ack    out  1       one-cycle completion pulse to CPU
//  dma_req    in   1       DMA access request; held until dma_ack
//  dma_we     in   1       1 = write, 0 = read
//  dma_addr   in   ADDR_W  DMA byte address
//  dma_wdata  in   DATA_W  DMA write data
//  dma_rdata  out  DATA_W  DMA read data, registered
//  dma_ack    out  1       one-cycle completion pulse to DMA
//  mem_addr   out  ADDR_W  address to memory
//  mem_wdata  out  DATA_W  write data to memory
//  mem_read   out  1       memory read strobe (MemRead)
//  mem_write  out  1       memory write strobe (MemWrite)
//  mem_rdata  in   DATA_W  memory read data (combinational)
//  busy       out  1       high while state != IDLE
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; cpu_rdata/dma_rdata 0.
//   - State IDLE; last_grant = DMA, so the CPU wins the first tie.
//  FSM states: IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE:
//   - mem_read = mem_write = 0; mem_addr/mem_wdata hold their last value.
//   - If any req is high at the edge: choose the winner, latch its we/addr/wdata into owner regs, load cnt = MEM_LAT-1, go to ACCESS.
//  Arbitration:
//   - Only one req high: that requester wins.
//   - Both high: the requester != last_grant wins.
//   - last_grant updates on entry to DONE.
//  ACCESS:
//   - mem_addr/mem_wdata come from the owner regs and stay stable for the whole state.
//   - mem_read = ~we, mem_write = we.
//   - cnt decrements each cycle. At cnt == 0: if read, capture mem_rdata into the owner's rdata reg; go to DONE.
//   - Repeated write cycles of the same word are idempotent; no byte-enable logic.
//  DONE:
//   - Owner's ack = 1 for exactly this cycle; strobes 0. Go to IDLE.
//   - A req still high in the next IDLE is a new request.
//  Latency:
//   - Req sampled at edge 0 -> strobes high in cycles 1..MEM_LAT -> ack high in cycle MEM_LAT+1.
//   - Back-to-back throughput: one access per MEM_LAT+2 cycles.
//  Registered read data:
//   - Holds until that port's next read completes.
//   - Write accesses leave rdata unchanged.
//  Boundary conditions:
//   - Req dropped mid-access: the access still completes and ack still pulses. No abort.
//   - Other port raises req during ACCESS/DONE: it waits and is arbitrated in the next IDLE.
//   - Addresses are passed through unmodified; no wrap or alignment check. Word alignment is the requester's duty.
//   - rst asserted mid-access: immediately IDLE, strobes/acks 0, rdata cleared, last_grant = DMA. The in-flight write may be partial.
//   - MEM_LAT = 1: ACCESS lasts one cycle and the counter is unused.
// STRUCTURE
//  Package mips_mem_pkg:
//   - arb_state_t enum {IDLE, ACCESS, DONE}
//   - MST_CPU = 1'b0, MST_DMA = 1'b1
//   - default ADDR_W/DATA_W
//  Sub-module arb_rr2:
//   - Combinational 2-way round-robin picker: (req[1:0], last_grant) -> (grant_valid, grant_id).
//   - The rest (FSM, counter, owner regs, output muxes) stays in this module.
// TESTING
//  1. Reset, then cpu_req read of 2000 with mem[2000..2003] = 0x12345678, MEM_LAT = 2
//     -> mem_read high cycles 1-2, mem_addr = 2000, cpu_ack in cycle 3, cpu_rdata = 0x12345678.
//  2. dma_req write 0xDEADBEEF to 2004
//     -> mem_write high 2 cycles, mem_addr = 2004, dma_ack in cycle 3;
//        {Mem[2004..2007]} = 0xDEADBEEF; cpu_rdata unchanged.
//  3. Both req held high continuously after reset
//     -> grants alternate CPU, DMA, CPU, DMA; an ack every 4 cycles; no double ack.
//  4. cpu_req dropped in cycle 1 of ACCESS
//     -> access completes, cpu_ack pulses in cycle 3, FSM returns to IDLE with no new access.
//  5. rst asserted during ACCESS of a write
//     -> mem_write, acks and busy go 0 without a clock edge;
//        after release a simultaneous request is granted to the CPU.
//  6. MEM_LAT = 1 build: single CPU read
//     -> mem_read high in cycle 1 only, cpu_ack in cycle 2, busy high cycles 1-2.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the multicycle MIPS memory arbiter.
// Master IDs double as bit positions in the two-bit request vector.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker.
// On a tie, the requester that did not win last time gets the grant.
module arb_rr2
  import mips_mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_id_o    = MST_CPU;
    if (req_i[MST_CPU] && req_i[MST_DMA]) begin
      grant_id_o = ~last_grant_i;
    end else if (req_i[MST_DMA]) begin
      grant_id_o = MST_DMA;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Serialises CPU and DMA accesses onto the single unified MIPS memory.
// Each access is held for MEM_LAT cycles, followed by a one-cycle ack to the owner.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic grant_valid;
  logic grant_id;

  arb_rr2 u_arb (
    .req_i        ({dma_req, cpu_req}),
    .last_grant_i (last_grant_q),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= MST_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= MST_DMA;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_id;
          we_d    = (grant_id == MST_DMA) ? dma_we    : cpu_we;
          addr_d  = (grant_id == MST_DMA) ? dma_addr  : cpu_addr;
          wdata_d = (grant_id == MST_DMA) ? dma_wdata : cpu_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Read data is sampled on the final strobe cycle, while the address is still driven.
          if (!we_q) begin
            if (owner_q == MST_DMA) dma_rdata_d = mem_rdata;
            else                    cpu_rdata_d = mem_rdata;
          end
          last_grant_d = owner_q;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and write data stay on the owner registers, so they hold through IDLE.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = (state_q == ACCESS) && !we_q;
  assign mem_write = (state_q == ACCESS) && we_q;
  assign cpu_ack   = (state_q == DONE) && (owner_q == MST_CPU);
  assign dma_ack   = (state_q == DONE) && (owner_q == MST_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed and randomized checks of mips_mem_arbiter against a transaction-level model
// (byte-array memory image, round-robin winner tracking, per-port read-data registers).
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-port stimulus: index 0 = CPU, 1 = DMA
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];

  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_read, mem_write, busy;
  logic [1:0]  ack_w;
  logic [31:0] rd_w [2];
  assign ack_w   = {dma_ack, cpu_ack};
  assign rd_w[0] = cpu_rdata;
  assign rd_w[1] = dma_rdata;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(req_v[0]), .cpu_we(we_v[0]), .cpu_addr(addr_v[0]), .cpu_wdata(wdata_v[0]),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(req_v[1]), .dma_we(we_v[1]), .dma_addr(addr_v[1]), .dma_wdata(wdata_v[1]),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Second build with single-cycle memory latency
  logic        c2_req;
  logic [31:0] c2_addr;
  logic [31:0] c2_cpu_rdata, c2_dma_rdata, c2_mem_addr, c2_mem_wdata, c2_mem_rdata;
  logic        c2_cpu_ack, c2_dma_ack, c2_mem_read, c2_mem_write, c2_busy;
  assign c2_mem_rdata = c2_mem_addr ^ 32'hA5A5_0000;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .cpu_req(c2_req), .cpu_we(1'b0), .cpu_addr(c2_addr), .cpu_wdata(32'h0),
    .cpu_rdata(c2_cpu_rdata), .cpu_ack(c2_cpu_ack),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(c2_dma_rdata), .dma_ack(c2_dma_ack),
    .mem_addr(c2_mem_addr), .mem_wdata(c2_mem_wdata), .mem_read(c2_mem_read),
    .mem_write(c2_mem_write), .mem_rdata(c2_mem_rdata), .busy(c2_busy)
  );

  // Big-endian byte-addressed memory with a loader port used during reset
  logic [7:0]  mem [0:8191];
  logic        ld_en;
  logic [12:0] ld_addr;
  logic [7:0]  ld_data;

  function automatic logic [12:0] bi(input logic [31:0] a, input int k);
    logic [31:0] s;
    s = a + 32'(k);
    return s[12:0];
  endfunction

  assign mem_rdata = {mem[bi(mem_addr, 0)], mem[bi(mem_addr, 1)],
                      mem[bi(mem_addr, 2)], mem[bi(mem_addr, 3)]};

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_write) begin
      mem[bi(mem_addr, 0)] <= mem_wdata[31:24];
      mem[bi(mem_addr, 1)] <= mem_wdata[23:16];
      mem[bi(mem_addr, 2)] <= mem_wdata[15:8];
      mem[bi(mem_addr, 3)] <= mem_wdata[7:0];
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [0:8191];
  int          ref_last;
  logic [31:0] ref_rd [2];
  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return {ref_mem[bi(a, 0)], ref_mem[bi(a, 1)], ref_mem[bi(a, 2)], ref_mem[bi(a, 3)]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ref_last  = 1;
    ref_rd[0] = '0;
    ref_rd[1] = '0;
  endtask

  task automatic do_reset();
    req_v = 2'b00;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // One complete access by port p, starting in an IDLE cycle with req_v[p] already high.
  task automatic serve(input int p, input bit keep, input bit drop_early);
    tick();
    if (drop_early) req_v[p] = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      chk($sformatf("p%0d c%0d mem_read", p, k), 32'(mem_read), 32'(!we_v[p]));
      chk($sformatf("p%0d c%0d mem_write", p, k), 32'(mem_write), 32'(we_v[p]));
      chk($sformatf("p%0d c%0d mem_addr", p, k), mem_addr, addr_v[p]);
      if (we_v[p]) chk($sformatf("p%0d c%0d mem_wdata", p, k), mem_wdata, wdata_v[p]);
      chk($sformatf("p%0d c%0d acks", p, k), 32'(ack_w), 32'(0));
      chk($sformatf("p%0d c%0d busy", p, k), 32'(busy), 32'(1));
      tick();
    end
    if (we_v[p]) begin
      for (int b = 0; b < 4; b++) ref_mem[bi(addr_v[p], b)] = wdata_v[p][31-8*b -: 8];
    end else begin
      ref_rd[p] = ref_word(addr_v[p]);
    end
    ref_last = p;
    chk($sformatf("p%0d done acks", p), 32'(ack_w), 32'(2'b01 << p));
    chk($sformatf("p%0d done strobes", p), 32'({mem_read, mem_write}), 32'(0));
    chk($sformatf("p%0d done busy", p), 32'(busy), 32'(1));
    chk($sformatf("p%0d done cpu_rdata", p), rd_w[0], ref_rd[0]);
    chk($sformatf("p%0d done dma_rdata", p), rd_w[1], ref_rd[1]);
    if (!keep) req_v[p] = 1'b0;
    tick();
    chk($sformatf("p%0d idle busy", p), 32'(busy), 32'(0));
    chk($sformatf("p%0d idle acks", p), 32'(ack_w), 32'(0));
    chk($sformatf("p%0d idle mem_addr hold", p), mem_addr, addr_v[p]);
  endtask

  initial begin
    logic [7:0] pre [4];
    logic [7:0] b8;
    int w, mode;
    pre[0] = 8'h12; pre[1] = 8'h34; pre[2] = 8'h56; pre[3] = 8'h78;
    req_v = 2'b00; we_v = 2'b00;
    addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
    c2_req = 1'b0; c2_addr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    rst = 1'b1;
    model_reset();

    // Preload window 2000..2063 while reset is held
    for (int i = 0; i < 64; i++) begin
      b8 = (i < 4) ? pre[i] : 8'($urandom);
      ld_en = 1'b1; ld_addr = 13'(2000 + i); ld_data = b8;
      ref_mem[2000 + i] = b8;
      tick();
    end
    ld_en = 1'b0;
    tick();

    chk("rst cpu_rdata", cpu_rdata, 32'h0);
    chk("rst dma_rdata", dma_rdata, 32'h0);
    chk("rst acks", 32'(ack_w), 32'(0));
    chk("rst strobes", 32'({mem_read, mem_write}), 32'(0));
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    tick();

    // CPU read of 2000
    we_v[0] = 1'b0; addr_v[0] = 32'd2000; req_v[0] = 1'b1;
    serve(0, 1'b0, 1'b0);
    chk("t1 cpu_rdata", cpu_rdata, 32'h1234_5678);

    // DMA write of 2004
    we_v[1] = 1'b1; addr_v[1] = 32'd2004; wdata_v[1] = 32'hDEAD_BEEF; req_v[1] = 1'b1;
    serve(1, 1'b0, 1'b0);
    chk("t2 mem word", {mem[2004], mem[2005], mem[2006], mem[2007]}, 32'hDEAD_BEEF);
    chk("t2 cpu_rdata kept", cpu_rdata, 32'h1234_5678);

    // Both held continuously after reset: CPU, DMA alternate
    do_reset();
    we_v[0] = 1'b0; addr_v[0] = 32'd2000;
    we_v[1] = 1'b1; addr_v[1] = 32'd2008; wdata_v[1] = 32'hCAFE_0001;
    req_v = 2'b11;
    serve(0, 1'b1, 1'b0);
    serve(1, 1'b1, 1'b0);
    serve(0, 1'b1, 1'b0);
    serve(1, 1'b1, 1'b0);
    serve(0, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b0);

    // CPU request dropped in the first ACCESS cycle
    we_v[0] = 1'b0; addr_v[0] = 32'd2008; req_v[0] = 1'b1;
    serve(0, 1'b0, 1'b1);
    tick();
    chk("t4 no new access", 32'(busy), 32'(0));

    // Reset in the middle of a DMA write
    we_v[1] = 1'b1; addr_v[1] = 32'd2016; wdata_v[1] = 32'h0BAD_F00D; req_v[1] = 1'b1;
    tick();
    chk("t5 write active", 32'(mem_write), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("t5 async mem_write", 32'(mem_write), 32'(0));
    chk("t5 async acks", 32'(ack_w), 32'(0));
    chk("t5 async busy", 32'(busy), 32'(0));
    chk("t5 async cpu_rdata", cpu_rdata, 32'h0);
    chk("t5 async dma_rdata", dma_rdata, 32'h0);
    req_v = 2'b00;
    tick();
    rst = 1'b0;
    model_reset();
    we_v[0] = 1'b0; addr_v[0] = 32'd2000;
    we_v[1] = 1'b0; addr_v[1] = 32'd2004;
    req_v = 2'b11;
    serve(0, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b0);

    // Single-cycle latency build: one CPU read
    c2_addr = 32'd2000; c2_req = 1'b1;
    tick();
    chk("t6 c1 mem_read", 32'(c2_mem_read), 32'(1));
    chk("t6 c1 mem_addr", c2_mem_addr, 32'd2000);
    chk("t6 c1 ack", 32'(c2_cpu_ack), 32'(0));
    chk("t6 c1 busy", 32'(c2_busy), 32'(1));
    tick();
    c2_req = 1'b0;
    chk("t6 c2 mem_read", 32'(c2_mem_read), 32'(0));
    chk("t6 c2 ack", 32'(c2_cpu_ack), 32'(1));
    chk("t6 c2 busy", 32'(c2_busy), 32'(1));
    chk("t6 c2 rdata", c2_cpu_rdata, 32'd2000 ^ 32'hA5A5_0000);
    tick();
    chk("t6 c3 busy", 32'(c2_busy), 32'(0));
    chk("t6 c3 ack", 32'(c2_cpu_ack), 32'(0));
    chk("t6 dma side idle", 32'({c2_dma_ack, c2_mem_write}), 32'(0));
    chk("t6 dma_rdata", c2_dma_rdata, 32'h0);
    chk("t6 mem_wdata", c2_mem_wdata, 32'h0);

    // Randomized mix of single and contended requests
    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      for (int p = 0; p < 2; p++) begin
        we_v[p]    = 1'($urandom_range(0, 1));
        addr_v[p]  = 32'd2000 + 32'(4 * $urandom_range(0, 15));
        wdata_v[p] = $urandom;
      end
      if (mode == 2) begin
        req_v = 2'b11;
        w = 1 - ref_last;
        serve(w, 1'b0, 1'b0);
        serve(1 - w, 1'b0, 1'b0);
      end else begin
        req_v[mode] = 1'b1;
        serve(mode, 1'b0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
